// File: rtl/coriolis_ker1_subker0_obuf.sv
// Output buffer for the coriolis_ker1_subker0 divider: converts FloPoCo words to
// IEEE-754 single and queues them behind a first-word-fall-through output register.
module coriolis_ker1_subker0_obuf #(
  parameter int STREAMW = 34,
  parameter int OUTW    = 32,
  parameter int DEPTH   = 16,
  parameter int SLACK   = 13
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ivalid_in1_s0,
  input  logic [STREAMW-1:0]         in1_s0,
  output logic                       iready,
  output logic                       ovalid,
  output logic [OUTW-1:0]            out1_s0,
  input  logic                       oready,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       ovf
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);

  // Handshake: a word moves on any edge where valid and ready are both high;
  // valid never depends on ready, and data holds while valid is high and ready is low.

  logic [OUTW-1:0] mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q, count_d;
  logic            ovalid_q;
  logic [OUTW-1:0] out_q;
  logic            ovf_q;

  logic [OUTW-1:0] conv;
  logic [CW-1:0]   mem_cnt;
  logic            push, pop, full, mem_empty;
  logic            load_slot, from_mem, bypass, wr_mem;

  always_comb begin
    conv = '0;
    unique case (in1_s0[STREAMW-1 -: 2])
      2'b00:   conv = {in1_s0[31], 31'b0};
      2'b01:   conv = in1_s0[31:0];
      2'b10:   conv = {in1_s0[31], 8'hFF, 23'b0};
      default: conv = 32'h7FC0_0000;
    endcase
  end

  assign full      = (count_q == CW'(DEPTH));
  assign pop       = ovalid_q & oready;
  assign push      = ivalid_in1_s0 & (~full | pop);
  // Entries behind the output register; the register itself counts as one.
  assign mem_cnt   = count_q - CW'(ovalid_q);
  assign mem_empty = (mem_cnt == '0);
  assign load_slot = ~ovalid_q | pop;
  assign from_mem  = load_slot & ~mem_empty;
  assign bypass    = load_slot & mem_empty & push;
  assign wr_mem    = push & ~bypass;

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_mem) mem_q[wr_ptr_q] <= conv;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovalid_q <= 1'b0;
      out_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      if (wr_mem) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (from_mem) begin
        out_q    <= mem_q[rd_ptr_q];
        rd_ptr_q <= rd_ptr_q + 1'b1;
        ovalid_q <= 1'b1;
      end else if (bypass) begin
        out_q    <= conv;
        ovalid_q <= 1'b1;
      end else if (load_slot) begin
        ovalid_q <= 1'b0;
      end
      if (ivalid_in1_s0 && full && !pop) ovf_q <= 1'b1;
    end
  end

  assign iready  = ~rst & ((DEPTH - int'(count_q)) >= SLACK);
  assign ovalid  = ovalid_q;
  assign out1_s0 = out_q;
  assign count   = count_q;
  assign ovf     = ovf_q;

endmodule

// File: tb/tb_coriolis_ker1_subker0_obuf.sv
// Directed bench for coriolis_ker1_subker0_obuf: conversion, FWFT timing,
// threshold, overflow, full push+pop and mid-stream reset.
module tb_coriolis_ker1_subker0_obuf;

  logic        clk = 1'b0;
  logic        rst;
  logic        ivalid_in1_s0;
  logic [33:0] in1_s0;
  logic        iready;
  logic        ovalid;
  logic [31:0] out1_s0;
  logic        oready;
  logic [4:0]  count;
  logic        ovf;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  coriolis_ker1_subker0_obuf dut (
    .clk(clk), .rst(rst), .ivalid_in1_s0(ivalid_in1_s0), .in1_s0(in1_s0),
    .iready(iready), .ovalid(ovalid), .out1_s0(out1_s0), .oready(oready),
    .count(count), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; ivalid_in1_s0 = 1'b0; in1_s0 = '0; oready = 1'b0;
    step(); step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1; ivalid_in1_s0 = 1'b0; in1_s0 = '0; oready = 1'b0;
    step(); step();
    checks++;
    if (count !== 5'd0 || ovalid !== 1'b0 || out1_s0 !== 32'h0 || ovf !== 1'b0 || iready !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: count=%0d ovalid=%b out=%h ovf=%b iready=%b, want 0/0/0/0/0",
               count, ovalid, out1_s0, ovf, iready);
    end
    rst = 1'b0;
    step();
    checks++;
    if (iready !== 1'b1 || ovalid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: iready=%b ovalid=%b, want 1/0", iready, ovalid);
    end
  endtask

  task automatic test_passthrough();
    oready = 1'b1;
    ivalid_in1_s0 = 1'b1; in1_s0 = {2'b01, 32'h3F80_0000};
    step();
    checks++;
    if (ovalid !== 1'b1 || out1_s0 !== 32'h3F80_0000 || count !== 5'd1) begin
      errors++;
      $display("FAIL pass_first: ovalid=%b out=%h count=%0d, want 1/3f800000/1", ovalid, out1_s0, count);
    end
    in1_s0 = {2'b01, 32'hC2C8_0000};
    step();
    checks++;
    if (ovalid !== 1'b1 || out1_s0 !== 32'hC2C8_0000 || count !== 5'd1) begin
      errors++;
      $display("FAIL pass_second: ovalid=%b out=%h count=%0d, want 1/c2c80000/1", ovalid, out1_s0, count);
    end
    ivalid_in1_s0 = 1'b0;
    step();
    checks++;
    if (ovalid !== 1'b0 || count !== 5'd0) begin
      errors++;
      $display("FAIL pass_drain: ovalid=%b count=%0d, want 0/0", ovalid, count);
    end
  endtask

  task automatic test_exceptions();
    logic [33:0] vin [3];
    logic [31:0] vexp [3];
    vin[0] = {2'b00, 1'b1, 31'h1234}; vexp[0] = 32'h8000_0000;
    vin[1] = {2'b10, 1'b0, 31'h0};    vexp[1] = 32'h7F80_0000;
    vin[2] = {2'b11, 32'h0};          vexp[2] = 32'h7FC0_0000;
    oready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ivalid_in1_s0 = 1'b1; in1_s0 = vin[i];
      step();
      checks++;
      if (ovalid !== 1'b1 || out1_s0 !== vexp[i]) begin
        errors++;
        $display("FAIL exn_%0d: ovalid=%b out=%h, want 1/%h", i, ovalid, out1_s0, vexp[i]);
      end
    end
    ivalid_in1_s0 = 1'b0;
    step();
    checks++;
    if (ovalid !== 1'b0 || count !== 5'd0) begin
      errors++;
      $display("FAIL exn_drain: ovalid=%b count=%0d, want 0/0", ovalid, count);
    end
  endtask

  // Fills to 16 with oready low; leaves the buffer full.
  task automatic test_threshold(input logic [31:0] base);
    logic exp_rdy;
    oready = 1'b0;
    exp_q.delete();
    for (int k = 1; k <= 16; k++) begin
      ivalid_in1_s0 = 1'b1; in1_s0 = {2'b01, base + 32'(k - 1)};
      exp_q.push_back(base + 32'(k - 1));
      step();
      exp_rdy = (k <= 3);
      checks++;
      if (count !== 5'(k) || iready !== exp_rdy || ovf !== 1'b0) begin
        errors++;
        $display("FAIL threshold_%0d: count=%0d iready=%b ovf=%b, want %0d/%b/0",
                 k, count, iready, ovf, k, exp_rdy);
      end
    end
    ivalid_in1_s0 = 1'b0;
  endtask

  task automatic drain_check(input string name);
    logic [31:0] e;
    int n;
    oready = 1'b1; ivalid_in1_s0 = 1'b0;
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      e = exp_q.pop_front();
      checks++;
      if (ovalid !== 1'b1 || out1_s0 !== e) begin
        errors++;
        $display("FAIL %s_word%0d: ovalid=%b out=%h, want 1/%h", name, i, ovalid, out1_s0, e);
      end
      step();
    end
    checks++;
    if (ovalid !== 1'b0 || count !== 5'd0) begin
      errors++;
      $display("FAIL %s_end: ovalid=%b count=%0d, want 0/0", name, ovalid, count);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    test_threshold(32'h0000_0100);
    ivalid_in1_s0 = 1'b1; in1_s0 = {2'b01, 32'h0000_DEAD};
    step();
    ivalid_in1_s0 = 1'b0;
    checks++;
    if (ovf !== 1'b1 || count !== 5'd16) begin
      errors++;
      $display("FAIL overflow_flag: ovf=%b count=%0d, want 1/16", ovf, count);
    end
    drain_check("overflow_drain");
    checks++;
    if (ovf !== 1'b1) begin
      errors++;
      $display("FAIL overflow_sticky: ovf=%b, want 1", ovf);
    end
  endtask

  task automatic test_full_push_pop();
    do_reset();
    test_threshold(32'h0000_0200);
    oready = 1'b1; ivalid_in1_s0 = 1'b1; in1_s0 = {2'b01, 32'h0000_02FF};
    void'(exp_q.pop_front());
    exp_q.push_back(32'h0000_02FF);
    step();
    ivalid_in1_s0 = 1'b0;
    checks++;
    if (count !== 5'd16 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL full_pushpop: count=%0d ovf=%b, want 16/0", count, ovf);
    end
    drain_check("full_drain");
  endtask

  task automatic test_reset_mid();
    do_reset();
    oready = 1'b0;
    for (int k = 0; k < 7; k++) begin
      ivalid_in1_s0 = 1'b1; in1_s0 = {2'b01, 32'h0000_0300 + 32'(k)};
      step();
    end
    ivalid_in1_s0 = 1'b0;
    checks++;
    if (count !== 5'd7) begin
      errors++;
      $display("FAIL mid_fill: count=%0d, want 7", count);
    end
    rst = 1'b1;
    step();
    checks++;
    if (ovalid !== 1'b0 || count !== 5'd0 || iready !== 1'b0) begin
      errors++;
      $display("FAIL mid_in_reset: ovalid=%b count=%0d iready=%b, want 0/0/0", ovalid, count, iready);
    end
    rst = 1'b0; oready = 1'b1;
    step();
    checks++;
    if (ovalid !== 1'b0 || iready !== 1'b1) begin
      errors++;
      $display("FAIL mid_release: ovalid=%b iready=%b, want 0/1", ovalid, iready);
    end
    ivalid_in1_s0 = 1'b1; in1_s0 = {2'b01, 32'h0000_03AA};
    step();
    ivalid_in1_s0 = 1'b0;
    checks++;
    if (ovalid !== 1'b1 || out1_s0 !== 32'h0000_03AA || count !== 5'd1) begin
      errors++;
      $display("FAIL mid_fresh: ovalid=%b out=%h count=%0d, want 1/000003aa/1", ovalid, out1_s0, count);
    end
    step();
    checks++;
    if (ovalid !== 1'b0 || count !== 5'd0) begin
      errors++;
      $display("FAIL mid_no_stale: ovalid=%b count=%0d, want 0/0", ovalid, count);
    end
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_exceptions();
    test_overflow();
    test_full_push_pop();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
